conv_out_buf: RTL

//  Output buffer directly downstream of the conv functional unit. Captures one

---
 rtl/conv_out_buf.sv | 134 +++++++++++++
 1 files changed

// File: rtl/conv_out_buf.sv
// Output buffer after the conv func unit: requantises each accumulated word,
// holds a full vector, then streams it to the next layer's loader.
module conv_out_buf #(
   parameter int output_size = 512,
   parameter int in_width    = 16,
   parameter int out_width   = 8,
   parameter int shift       = 4,
   parameter int relu_en     = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_we,
   input  logic [in_width-1:0]  i_data,
   output logic                 o_busy,
   input  logic                 i_next_busy,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [out_width-1:0] o_data,
   output logic                 o_last,
   output logic                 o_start,
   output logic                 o_err
);

   localparam int AW = $clog2(output_size);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] LAST = PW'(output_size - 1);

   localparam logic signed [in_width-1:0] QMAX =
      in_width'(2 ** (out_width - 1) - 1);
   localparam logic signed [in_width-1:0] QMIN =
      in_width'(-(2 ** (out_width - 1)));

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      FULL  = 2'd1,
      DRAIN = 2'd2,
      START = 2'd3
   } state_t;

   state_t state, state_nx;

   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [out_width-1:0] mem [output_size];
   logic                 wr_ok, rd_acc;

   logic signed [in_width-1:0] t_sh, t_rl;
   logic [out_width-1:0]       q;

   assign wr_ok  = i_we && (state == FILL);
   assign rd_acc = (state == DRAIN) && i_ready;

   // Requantise: arithmetic shift, optional ReLU, saturate to out_width.
   always_comb begin
      t_sh = $signed(i_data) >>> shift;
      t_rl = t_sh;
      if (relu_en != 0 && t_sh[in_width-1])
         t_rl = '0;
      if (t_rl > QMAX)
         q = QMAX[out_width-1:0];
      else if (t_rl < QMIN)
         q = QMIN[out_width-1:0];
      else
         q = t_rl[out_width-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_ok)
         mem[wr_ptr[AW-1:0]] <= q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= FILL;
         wr_ptr <= '0;
         rd_ptr <= '0;
         o_err  <= 1'b0;
      end else begin
         state <= state_nx;
         if (i_we && o_busy)
            o_err <= 1'b1;
         case (state)
            FILL: begin
               if (wr_ok)
                  wr_ptr <= wr_ptr + PW'(1);
            end
            FULL: begin
               rd_ptr <= '0;
            end
            DRAIN: begin
               if (rd_acc)
                  rd_ptr <= rd_ptr + PW'(1);
            end
            default: begin
               wr_ptr <= '0;
               rd_ptr <= '0;
            end
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         FILL: begin
            if (wr_ok && wr_ptr == LAST)
               state_nx = FULL;
         end
         FULL: begin
            if (!i_next_busy)
               state_nx = DRAIN;
         end
         DRAIN: begin
            if (rd_acc && rd_ptr == LAST)
               state_nx = START;
         end
         START:   state_nx = FILL;
         default: state_nx = FILL;
      endcase
   end

   always_comb begin
      o_busy  = (state != FILL);
      o_valid = 1'b0;
      o_data  = '0;
      o_last  = 1'b0;
      o_start = (state == START);
      if (state == DRAIN) begin
         o_valid = 1'b1;
         o_data  = mem[rd_ptr[AW-1:0]];
         o_last  = (rd_ptr == LAST);
      end
   end

endmodule
